// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the memory stage: icodes, status codes, register ids,
// the memory->writeback register layout and its bubble value.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } w_reg_t;

    localparam w_reg_t W_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        valE:  64'd0,
        valM:  64'd0,
        dstE:  R_NONE,
        dstM:  R_NONE
    };

    function automatic logic is_mem_read(input logic [3:0] icode);
        return (icode == I_MRMOV) || (icode == I_POP) || (icode == I_RET);
    endfunction

    function automatic logic is_mem_write(input logic [3:0] icode);
        return (icode == I_RMMOV) || (icode == I_PUSH) || (icode == I_CALL);
    endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory: combinational 8-byte read, 8-byte write on clk.
// Latency: read 0 cycles, write lands on the next rising edge; no backpressure (accesses never stall).
// Out-of-range accesses raise error, return zero and never modify the array.
module data_mem #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata,
    output logic              error
);

    localparam int                IDX_W   = $clog2(MEM_BYTES);
    localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

    logic [7:0]       mem_q [MEM_BYTES];
    logic [IDX_W-1:0] base;
    logic             we;

    // Full-width unsigned compare so wrapped addresses near 2^64 are rejected.
    assign error = (rd_en || wr_en) && (addr > LAST_OK);
    assign base  = addr[IDX_W-1:0];
    assign we    = wr_en && !error && rst_n;

    always_comb begin
        rdata = 64'd0;
        if (rd_en && !error) begin
            for (int i = 0; i < 8; i++) begin
                rdata[8*i +: 8] = mem_q[base + IDX_W'(i)];
            end
        end
    end

    // Contents survive reset; only the write strobe is gated by it.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[base + IDX_W'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: data-memory access, status/destination decode and the W pipeline register.
// Latency: mem_valM/mem_stat combinational, W outputs one cycle after the M inputs.
// Backpressure: w_stall holds W, w_bubble (higher priority) loads a nop; memory writes ignore both.
module mem_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [3:0]        m_rA,
    input  logic [3:0]        m_rB,
    input  logic [63:0]       m_valC,
    input  logic [63:0]       m_valP,
    input  logic [ADDR_W-1:0] m_valA,
    input  logic [63:0]       m_valB,
    input  logic              m_cnd,
    input  logic [ADDR_W-1:0] m_valE,
    input  logic              w_stall,
    input  logic              w_bubble,
    output logic [63:0]       mem_valM,
    output logic [2:0]        mem_stat,
    output logic [2:0]        w_stat,
    output logic [3:0]        w_icode,
    output logic [63:0]       w_valE,
    output logic [63:0]       w_valM,
    output logic [3:0]        w_dstE,
    output logic [3:0]        w_dstM
);

    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              dmem_error;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    w_reg_t            w_d;
    w_reg_t            w_q;
    logic              unused_m;

    assign unused_m = ^{m_valB, m_valC};

    assign mem_rd = is_mem_read(m_icode);
    assign mem_wr = is_mem_write(m_icode);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = 64'(m_valA);
        unique case (m_icode)
            I_RMMOV, I_PUSH, I_MRMOV: mem_addr = m_valE;
            I_CALL: begin
                mem_addr  = m_valE;
                mem_wdata = m_valP;
            end
            I_POP, I_RET: mem_addr = m_valA;
            default: mem_addr = '0;
        endcase
    end

    always_comb begin
        dst_e = R_NONE;
        unique case (m_icode)
            I_CMOV:                        dst_e = m_cnd ? m_rB : R_NONE;
            I_IRMOV, I_OPQ:                dst_e = m_rB;
            I_CALL, I_RET, I_PUSH, I_POP:  dst_e = R_RSP;
            default:                       dst_e = R_NONE;
        endcase
    end

    assign dst_m = (m_icode == I_MRMOV || m_icode == I_POP) ? m_rA : R_NONE;

    // Faulted or non-AOK instructions must not leave side effects in memory.
    data_mem #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_dmem (
        .clk   (clk),
        .rst_n (rst_n),
        .rd_en (mem_rd),
        .wr_en (mem_wr && (m_stat == S_AOK)),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_valM),
        .error (dmem_error)
    );

    assign mem_stat = dmem_error ? S_ADR : m_stat;

    always_comb begin
        w_d       = W_BUBBLE;
        w_d.stat  = mem_stat;
        w_d.icode = m_icode;
        w_d.valE  = 64'(m_valE);
        w_d.valM  = mem_valM;
        w_d.dstE  = dst_e;
        w_d.dstM  = dst_m;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= W_BUBBLE;
        end else if (w_bubble) begin
            w_q <= W_BUBBLE;
        end else if (!w_stall) begin
            w_q <= w_d;
        end
    end

    assign w_stat  = w_q.stat;
    assign w_icode = w_q.icode;
    assign w_valE  = w_q.valE;
    assign w_valM  = w_q.valM;
    assign w_dstE  = w_q.dstE;
    assign w_dstM  = w_q.dstM;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected W contents are queued as each instruction is driven
// and popped after the following clock edge; combinational outputs are checked in-cycle.
module tb_mem_stage;

    localparam logic [3:0] NOP = 4'h1, CMOV = 4'h2, RMMOV = 4'h4, MRMOV = 4'h5, OPQ = 4'h6;
    localparam logic [3:0] CALL = 4'h8, RET = 4'h9, PUSH = 4'hA;
    localparam logic [2:0] AOK = 3'd1, ADR = 3'd3, INS = 3'd4;
    localparam logic [3:0] RSP = 4'h4, RNONE = 4'hF;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  m_stat;
    logic [3:0]  m_icode, m_rA, m_rB;
    logic [63:0] m_valC, m_valP, m_valA, m_valB, m_valE;
    logic        m_cnd, w_stall, w_bubble;
    logic [63:0] mem_valM;
    logic [2:0]  mem_stat, w_stat;
    logic [3:0]  w_icode, w_dstE, w_dstM;
    logic [63:0] w_valE, w_valM;

    exp_t sb_q[$];
    exp_t held;
    int   n_checks = 0;
    int   n_fails  = 0;

    mem_stage #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_stat(m_stat), .m_icode(m_icode), .m_rA(m_rA), .m_rB(m_rB),
        .m_valC(m_valC), .m_valP(m_valP), .m_valA(m_valA), .m_valB(m_valB),
        .m_cnd(m_cnd), .m_valE(m_valE),
        .w_stall(w_stall), .w_bubble(w_bubble),
        .mem_valM(mem_valM), .mem_stat(mem_stat),
        .w_stat(w_stat), .w_icode(w_icode), .w_valE(w_valE), .w_valM(w_valM),
        .w_dstE(w_dstE), .w_dstM(w_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic [63:0] va, input logic [63:0] vp,
                         input logic [63:0] ve, input logic cnd);
        m_stat = st; m_icode = ic; m_rA = ra; m_rB = rb;
        m_valA = va; m_valP = vp; m_valE = ve; m_cnd = cnd;
        m_valB = 64'hBBBB_0000_BBBB_0000; m_valC = 64'hCCCC_0000_CCCC_0000;
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                                input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        exp_t e;
        e.stat = st; e.icode = ic; e.valE = ve; e.valM = vm; e.dstE = de; e.dstM = dm;
        return e;
    endfunction

    task automatic chk_w(input string tag, input exp_t e);
        chk({tag, ".w_stat"},  64'(w_stat),  64'(e.stat));
        chk({tag, ".w_icode"}, 64'(w_icode), 64'(e.icode));
        chk({tag, ".w_valE"},  w_valE,       e.valE);
        chk({tag, ".w_valM"},  w_valM,       e.valM);
        chk({tag, ".w_dstE"},  64'(w_dstE),  64'(e.dstE));
        chk({tag, ".w_dstM"},  64'(w_dstM),  64'(e.dstM));
    endtask

    // Advance one edge and compare W against the oldest queued expectation.
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, ".queue_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk_w(tag, e);
        end
    endtask

    initial begin
        exp_t bub;
        bub = mk(AOK, NOP, 64'd0, 64'd0, RNONE, RNONE);
        w_stall = 1'b0; w_bubble = 1'b0;
        drive(AOK, NOP, RNONE, RNONE, 0, 0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_w("reset", bub);
        rst_n = 1'b1;

        // Store then load
        drive(AOK, RMMOV, 4'h1, 4'h2, 64'h1122_3344_5566_7788, 0, 64'h10, 1'b0);
        #1;
        chk("st.mem_stat", 64'(mem_stat), 64'(AOK));
        chk("st.mem_valM", mem_valM, 64'd0);
        sb_q.push_back(mk(AOK, RMMOV, 64'h10, 64'd0, RNONE, RNONE));
        tick("st");

        drive(AOK, MRMOV, 4'h3, RNONE, 0, 0, 64'h10, 1'b0);
        #1;
        chk("ld.byte10", 64'(mem_valM[7:0]), 64'h88);
        chk("ld.mem_valM", mem_valM, 64'h1122_3344_5566_7788);
        sb_q.push_back(mk(AOK, MRMOV, 64'h10, 64'h1122_3344_5566_7788, RNONE, 4'h3));
        tick("ld");

        // Boundary
        drive(AOK, RMMOV, 4'h1, 4'h2, 64'hA5A5_5A5A_0F0F_F0F0, 0, 64'd1016, 1'b0);
        #1;
        chk("st1016.mem_stat", 64'(mem_stat), 64'(AOK));
        sb_q.push_back(mk(AOK, RMMOV, 64'd1016, 64'd0, RNONE, RNONE));
        tick("st1016");

        drive(AOK, MRMOV, 4'h7, RNONE, 0, 0, 64'd1016, 1'b0);
        #1;
        chk("ld1016.mem_stat", 64'(mem_stat), 64'(AOK));
        chk("ld1016.mem_valM", mem_valM, 64'hA5A5_5A5A_0F0F_F0F0);
        sb_q.push_back(mk(AOK, MRMOV, 64'd1016, 64'hA5A5_5A5A_0F0F_F0F0, RNONE, 4'h7));
        tick("ld1016");

        drive(AOK, MRMOV, 4'h7, RNONE, 0, 0, 64'd1017, 1'b0);
        #1;
        chk("ld1017.mem_stat", 64'(mem_stat), 64'(ADR));
        chk("ld1017.mem_valM", mem_valM, 64'd0);
        sb_q.push_back(mk(ADR, MRMOV, 64'd1017, 64'd0, RNONE, 4'h7));
        tick("ld1017");

        // Write suppression
        drive(AOK, RMMOV, 4'h1, 4'h2, 64'h0102_0304_0506_0708, 0, 64'h20, 1'b0);
        #1;
        sb_q.push_back(mk(AOK, RMMOV, 64'h20, 64'd0, RNONE, RNONE));
        tick("st20");

        drive(AOK, PUSH, 4'h1, RNONE, 64'hDEAD_BEEF_DEAD_BEEF, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0);
        #1;
        chk("push.mem_stat", 64'(mem_stat), 64'(ADR));
        sb_q.push_back(mk(ADR, PUSH, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, RSP, RNONE));
        tick("push");

        drive(INS, RMMOV, 4'h1, 4'h2, 64'h0BAD_0BAD_0BAD_0BAD, 0, 64'h20, 1'b0);
        #1;
        chk("ins.mem_stat", 64'(mem_stat), 64'(INS));
        sb_q.push_back(mk(INS, RMMOV, 64'h20, 64'd0, RNONE, RNONE));
        tick("ins");

        drive(AOK, MRMOV, 4'h2, RNONE, 0, 0, 64'h20, 1'b0);
        #1;
        chk("ld20.mem_valM", mem_valM, 64'h0102_0304_0506_0708);
        sb_q.push_back(mk(AOK, MRMOV, 64'h20, 64'h0102_0304_0506_0708, RNONE, 4'h2));
        tick("ld20");

        // Low address bits of the wrapped PUSH alias 1016; it must still hold the old data.
        drive(AOK, MRMOV, 4'h7, RNONE, 0, 0, 64'd1016, 1'b0);
        #1;
        chk("ld1016b.mem_valM", mem_valM, 64'hA5A5_5A5A_0F0F_F0F0);
        sb_q.push_back(mk(AOK, MRMOV, 64'd1016, 64'hA5A5_5A5A_0F0F_F0F0, RNONE, 4'h7));
        tick("ld1016b");

        // CALL / RET
        drive(AOK, CALL, RNONE, RNONE, 64'h999, 64'h42, 64'h100, 1'b0);
        #1;
        sb_q.push_back(mk(AOK, CALL, 64'h100, 64'd0, RSP, RNONE));
        tick("call");

        drive(AOK, RET, RNONE, RNONE, 64'h100, 0, 64'h108, 1'b0);
        #1;
        chk("ret.mem_valM", mem_valM, 64'h42);
        sb_q.push_back(mk(AOK, RET, 64'h108, 64'h42, RSP, RNONE));
        tick("ret");

        // CMOV and stall/bubble
        drive(AOK, CMOV, 4'h1, 4'h5, 0, 0, 64'h7, 1'b0);
        #1;
        sb_q.push_back(mk(AOK, CMOV, 64'h7, 64'd0, RNONE, RNONE));
        tick("cmov0");

        drive(AOK, CMOV, 4'h1, 4'h5, 0, 0, 64'h9, 1'b1);
        #1;
        held = mk(AOK, CMOV, 64'h9, 64'd0, 4'h5, RNONE);
        sb_q.push_back(held);
        tick("cmov1");

        w_stall = 1'b1;
        drive(AOK, RMMOV, 4'h1, 4'h2, 64'h77, 0, 64'h40, 1'b0);
        #1;
        sb_q.push_back(held);
        tick("stall1");
        drive(AOK, OPQ, 4'h1, 4'h6, 0, 0, 64'h55, 1'b0);
        #1;
        sb_q.push_back(held);
        tick("stall2");

        w_bubble = 1'b1;
        #1;
        sb_q.push_back(bub);
        tick("bubble");
        w_stall = 1'b0; w_bubble = 1'b0;

        drive(AOK, MRMOV, 4'h3, RNONE, 0, 0, 64'h40, 1'b0);
        #1;
        chk("ld40.mem_valM", mem_valM, 64'h77);
        sb_q.push_back(mk(AOK, MRMOV, 64'h40, 64'h77, RNONE, 4'h3));
        tick("ld40");

        // Async reset with a pending write
        drive(AOK, RMMOV, 4'h1, 4'h2, 64'h1111, 0, 64'h30, 1'b0);
        #1;
        sb_q.push_back(mk(AOK, RMMOV, 64'h30, 64'd0, RNONE, RNONE));
        tick("st30");

        drive(AOK, RMMOV, 4'h1, 4'h2, 64'h2222, 0, 64'h30, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_w("arst", bub);
        @(posedge clk);
        #1;
        drive(AOK, NOP, RNONE, RNONE, 0, 0, 0, 1'b0);
        rst_n = 1'b1;

        drive(AOK, MRMOV, 4'h3, RNONE, 0, 0, 64'h30, 1'b0);
        #1;
        chk("ld30.mem_valM", mem_valM, 64'h1111);
        sb_q.push_back(mk(AOK, MRMOV, 64'h30, 64'h1111, RNONE, 4'h3));
        tick("ld30");

        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the Y86-64 pipeline. Sits between the execute→memory pipeline register (consumes its m_* outputs) and the writeback stage.
- Performs the data-memory read/write, computes memory-stage status and destination registers, and holds the memory→writeback pipeline register (W) with stall/bubble control.
- Provides combinational mem_valM and mem_stat for forwarding and hazard control.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes; byte-addressed, little-endian, 8-byte accesses.
- ADDR_W, 64: address width (valE/valA width).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m_stat  in  3  status from M register
- m_icode  in  4  instruction code
- m_rA  in  4  register A
- m_rB  in  4  register B
- m_valC  in  64  constant (unused except pass-through)
- m_valP  in  64  incremented PC
- m_valA  in  64  operand A
- m_valB  in  64  operand B (unused)
- m_cnd  in  1  condition result
- m_valE  in  64  ALU result
- w_stall  in  1  hold W register
- w_bubble  in  1  load nop into W register
- mem_valM  out  64  combinational read data (forwarding)
- mem_stat  out  3  combinational memory-stage status
- w_stat  out  3  W register status
- w_icode  out  4  W register icode
- w_valE  out  64  W register valE
- w_valM  out  64  W register valM
- w_dstE  out  4  W register dstE
- w_dstM  out  4  W register dstM

Behaviour:
- Codes: icodes HALT=0 NOP=1 CMOV=2 IRMOV=3 RMMOV=4 MRMOV=5 OPQ=6 JXX=7 CALL=8 RET=9 PUSH=A POP=B. Stat AOK=1 HLT=2 ADR=3 INS=4. RSP=4, RNONE=F.
- Address: valE for RMMOV, PUSH, CALL, MRMOV; valA for POP, RET; otherwise none.
- Read when icode is MRMOV, POP or RET. Write when icode is RMMOV, PUSH or CALL.
- Write data: m_valA for RMMOV and PUSH; m_valP for CALL.
- Address error (dmem_error): a read or write is active and addr > MEM_BYTES-8, compared unsigned on the full 64 bits. This includes wrap-around addresses such as 0xFFFF_FFFF_FFFF_FFFC.
- Status: mem_stat = ADR if dmem_error, else m_stat.
- Read path:
  - Combinational: mem_valM is bytes addr..addr+7, little-endian.
  - mem_valM = 0 when no read is active or dmem_error is set.
- Write path:
  - Synchronous, on the rising clk edge. All 8 bytes are written in the same edge.
  - Suppressed if dmem_error, m_stat != AOK, or rst_n low.
  - Not affected by w_stall or w_bubble.
- Read-during-write: a read in the same cycle returns the old contents. A following instruction observes the new data on the next cycle.
- dstE:
  - CMOV: rB if m_cnd, else RNONE.
  - IRMOV, OPQ: rB.
  - CALL, RET, PUSH, POP: RSP.
  - Otherwise RNONE.
- dstM: rA for MRMOV and POP; otherwise RNONE.
- W register, on the rising clk edge:
  - w_bubble=1: load the bubble value (stat AOK, icode NOP, valE 0, valM 0, dstE RNONE, dstM RNONE). w_bubble has priority over w_stall.
  - Else w_stall=1: hold all W outputs.
  - Else load {mem_stat, m_icode, m_valE, mem_valM, dstE, dstM}.
- Latency: one cycle from M-register inputs to W outputs. mem_valM and mem_stat have zero latency.
- Reset:
  - rst_n low immediately forces all W outputs to the bubble value, asynchronously.
  - Reset during a cycle with a pending write blocks that write.
  - Memory contents are not cleared by reset.
- HLT and INS statuses pass through unchanged. The stage performs no access beyond the icode-decoded one.

Decomposition:
- Package y86_pkg: icode constants, stat constants, RSP, RNONE, bubble-value constants.
- Sub-module data_mem:
  - Byte array of MEM_BYTES.
  - Combinational 8-byte read, synchronous 8-byte write.
  - Exposes an error flag for bounds.
- mem_stage instantiates data_mem and contains the decode logic and the W register.

Test Plan:
- Store then load:
  - Stimulus: RMMOV (valE=0x10, valA=0x1122334455667788), then MRMOV (valE=0x10, rA=3).
  - Response: byte 0x10 = 0x88. W after the second edge: valM=0x1122334455667788, dstM=3, stat AOK.
- Boundary:
  - Stimulus: MRMOV at valE=MEM_BYTES-8 (1016), then at 1017.
  - Response: first gives stat AOK. Second gives mem_stat=ADR, mem_valM=0, w_stat=ADR.
- Write suppression:
  - Stimulus: PUSH at valE=0xFFFFFFFFFFFFFFF8, then RMMOV with m_stat=INS at valE=0x20.
  - Response: both leave memory unchanged. PUSH gives ADR with dstE=RSP.
- CALL/RET:
  - Stimulus: CALL (valE=0x100, valP=0x42), then RET (valA=0x100).
  - Response: RET gives mem_valM=0x42, w_dstE=RSP, w_dstM=RNONE.
- CMOV and stall/bubble:
  - Stimulus: CMOV rB=5 with cnd=0, then cnd=1; then w_stall=1 for 2 cycles; then w_stall=1 with w_bubble=1.
  - Response: dstE goes F, then 5. W holds its value while stalled. The bubble value wins when both are asserted.
- Async reset:
  - Stimulus: drop rst_n mid-cycle while RMMOV to 0x30 is pending.
  - Response: W outputs become the bubble value immediately, without a clock edge. Byte 0x30 is unchanged.
